// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register/counter.
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_JK   = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// One falling-edge JK storage bit with synchronous reset, clock enable and parallel load.
module jk_cell (
   input  logic Clk,
   input  logic Reset,
   input  logic Reset_value,
   input  logic En,
   input  logic J,
   input  logic K,
   input  logic Load,
   input  logic D,
   output logic Q
);

   always_ff @(negedge Clk) begin
      if (Reset) begin
         Q <= Reset_value;
      end else if (En) begin
         if (Load) begin
            Q <= D;
         end else begin
            case ({J, K})
               2'b10:   Q <= 1'b1;
               2'b01:   Q <= 1'b0;
               2'b11:   Q <= ~Q;
               default: Q <= Q;
            endcase
         end
      end
   end

endmodule

// File: rtl/jk_register_counter.sv
// WIDTH-bit register of JK cells: bitwise JK, up/down count with optional saturation, parallel load.
module jk_register_counter
   import jk_pkg::*;
#(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter bit                SATURATE    = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_bar,
   output logic             TC,
   output logic             Wrap
);

   jk_mode_t         mode;
   logic [WIDTH-1:0] toggle;
   logic             chain;
   logic             all_ones;
   logic             all_zero;
   logic             sat_hold;
   logic [WIDTH-1:0] cell_j;
   logic [WIDTH-1:0] cell_k;
   logic [WIDTH-1:0] cell_load;
   logic [WIDTH-1:0] next_count;

   assign mode     = jk_mode_t'(Mode);
   assign all_ones = &Q;
   assign all_zero = ~|Q;
   assign Q_bar    = ~Q;

   // Ripple toggle chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
   always_comb begin
      toggle = '0;
      chain  = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         toggle[i] = chain;
         chain     = chain & ((mode == MODE_DOWN) ? ~Q[i] : Q[i]);
      end
   end

   assign sat_hold   = SATURATE && (((mode == MODE_UP) && all_ones) ||
                                    ((mode == MODE_DOWN) && all_zero));
   assign next_count = Q ^ (sat_hold ? '0 : toggle);

   always_comb begin
      cell_j    = '0;
      cell_k    = '0;
      cell_load = '0;
      case (mode)
         MODE_JK: begin
            cell_j = J;
            cell_k = K;
         end
         MODE_UP, MODE_DOWN: begin
            cell_j = sat_hold ? '0 : toggle;
            cell_k = sat_hold ? '0 : toggle;
         end
         MODE_LOAD: cell_load = '1;
         default: ;
      endcase
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .Clk         (Clk),
         .Reset       (Reset),
         .Reset_value (RESET_VALUE[g]),
         .En          (En),
         .J           (cell_j[g]),
         .K           (cell_k[g]),
         .Load        (cell_load[g]),
         .D           (D[g]),
         .Q           (Q[g])
      );
   end

   always_ff @(negedge Clk) begin
      if (Reset) begin
         TC   <= 1'b0;
         Wrap <= 1'b0;
      end else if (!En) begin
         Wrap <= 1'b0;
      end else begin
         case (mode)
            MODE_UP: begin
               TC   <= &next_count;
               Wrap <= !SATURATE && all_ones;
            end
            MODE_DOWN: begin
               TC   <= ~|next_count;
               Wrap <= !SATURATE && all_zero;
            end
            default: begin
               TC   <= 1'b0;
               Wrap <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_register_counter.sv
// Bench for jk_register_counter: three configurations driven in lockstep against an arithmetic reference model.
module tb_jk_register_counter;

   logic        Clk = 1'b0;
   logic        Reset, En;
   logic [1:0]  Mode;
   logic [3:0]  J4, K4, D4;
   logic [15:0] J16, K16, D16;

   logic [3:0]  qa, qba, qs, qbs;
   logic        tca, wra, tcs, wrs;
   logic [15:0] qw, qbw;
   logic        tcw, wrw;

   logic [15:0] ma_q, ms_q, mw_q;
   bit          ma_tc, ma_wr, ms_tc, ms_wr, mw_tc, mw_wr;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   jk_register_counter #(.WIDTH(4), .RESET_VALUE(4'hA), .SATURATE(1'b0)) u_wrap4 (
      .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .J(J4), .K(K4), .D(D4),
      .Q(qa), .Q_bar(qba), .TC(tca), .Wrap(wra));

   jk_register_counter #(.WIDTH(4), .RESET_VALUE(4'hA), .SATURATE(1'b1)) u_sat4 (
      .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .J(J4), .K(K4), .D(D4),
      .Q(qs), .Q_bar(qbs), .TC(tcs), .Wrap(wrs));

   jk_register_counter #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1'b0)) u_wide16 (
      .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .J(J16), .K(K16), .D(D16),
      .Q(qw), .Q_bar(qbw), .TC(tcw), .Wrap(wrw));

   // Reference: behaviour as plain unsigned arithmetic on the value.
   task automatic model_one(input int w, input bit sat, input logic [15:0] rv,
                            input logic [15:0] j, input logic [15:0] k, input logic [15:0] d,
                            inout logic [15:0] q, inout bit tc, inout bit wr);
      logic [15:0] mask;
      mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
      if (Reset) begin
         q = rv; tc = 0; wr = 0;
      end else if (!En) begin
         wr = 0;
      end else begin
         case (Mode)
            2'b00: begin
               for (int b = 0; b < w; b++) begin
                  if (j[b] && k[b])  q[b] = ~q[b];
                  else if (j[b])     q[b] = 1'b1;
                  else if (k[b])     q[b] = 1'b0;
               end
               tc = 0; wr = 0;
            end
            2'b01: begin
               wr = 0;
               if (q == mask) begin
                  if (!sat) begin q = 0; wr = 1; end
               end else q = q + 16'd1;
               tc = (q == mask);
            end
            2'b10: begin
               wr = 0;
               if (q == 0) begin
                  if (!sat) begin q = mask; wr = 1; end
               end else q = q - 16'd1;
               tc = (q == 0);
            end
            default: begin
               q = d & mask; tc = 0; wr = 0;
            end
         endcase
      end
   endtask

   task automatic tick();
      model_one(4,  1'b0, 16'h000A, {12'h0, J4}, {12'h0, K4}, {12'h0, D4}, ma_q, ma_tc, ma_wr);
      model_one(4,  1'b1, 16'h000A, {12'h0, J4}, {12'h0, K4}, {12'h0, D4}, ms_q, ms_tc, ms_wr);
      model_one(16, 1'b0, 16'h0000, J16, K16, D16, mw_q, mw_tc, mw_wr);
      @(negedge Clk);
      #1;
   endtask

   function automatic logic [53:0] observed();
      return {qa, qba, tca, wra, qs, qbs, tcs, wrs, qw, qbw, tcw, wrw};
   endfunction

   function automatic logic [53:0] expected();
      return {ma_q[3:0], ~ma_q[3:0], ma_tc, ma_wr,
              ms_q[3:0], ~ms_q[3:0], ms_tc, ms_wr,
              mw_q, ~mw_q, mw_tc, mw_wr};
   endfunction

   task automatic test_reset();
      Reset = 1; En = 0; Mode = 2'b00;
      repeat (2) tick();
      checks++;
      if ({qa, qba, tca, wra, qs, tcs, wrs, qw, tcw, wrw} !== {4'hA, 4'h5, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: qa=%h qba=%h tc=%b wrap=%b qs=%h qw=%h, want qa=a qba=5 tc=0 wrap=0 qs=a qw=0000", qa, qba, tca, wra, qs, qw);
      end
      Reset = 0; En = 0;
      repeat (3) begin
         tick();
         checks++;
         if (qa !== 4'hA || qs !== 4'hA) begin
            errors++;
            $display("FAIL reset_hold_en0: qa=%h qs=%h, want a", qa, qs);
         end
      end
   endtask

   task automatic test_jk();
      En = 1; Mode = 2'b11; D4 = 4'b0101; D16 = 16'h5A5A;
      tick();
      Mode = 2'b00; J4 = 4'b1100; K4 = 4'b1010;
      J16 = 16'($urandom); K16 = 16'($urandom);
      tick();
      checks++;
      if (qa !== 4'b1101 || qs !== 4'b1101 || tca !== 1'b0 || wra !== 1'b0) begin
         errors++;
         $display("FAIL jk_bitwise: qa=%b qs=%b tc=%b wrap=%b, want 1101 1101 0 0", qa, qs, tca, wra);
      end
      checks++;
      if (observed() !== expected()) begin
         errors++;
         $display("FAIL jk_model: got %h want %h", observed(), expected());
      end
   endtask

   task automatic test_count_up();
      logic [3:0] want_q [3];
      logic [2:0] want_tc, want_wr;
      want_q = '{4'hE, 4'hF, 4'h0};
      want_tc = 3'b010;
      want_wr = 3'b100;
      En = 1; Mode = 2'b11; D4 = 4'hD;
      tick();
      Mode = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (qa !== want_q[i] || tca !== want_tc[i] || wra !== want_wr[i]) begin
            errors++;
            $display("FAIL count_up step %0d: q=%h tc=%b wrap=%b, want q=%h tc=%b wrap=%b",
                     i, qa, tca, wra, want_q[i], want_tc[i], want_wr[i]);
         end
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL count_up_model step %0d: got %h want %h", i, observed(), expected());
         end
      end
   endtask

   task automatic test_count_down();
      En = 1; Mode = 2'b11; D4 = 4'h1;
      tick();
      Mode = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (qs !== 4'h0 || tcs !== 1'b1 || wrs !== 1'b0) begin
            errors++;
            $display("FAIL count_down_sat step %0d: q=%h tc=%b wrap=%b, want q=0 tc=1 wrap=0", i, qs, tcs, wrs);
         end
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL count_down_model step %0d: got %h want %h", i, observed(), expected());
         end
      end
   endtask

   task automatic test_mid_control();
      En = 1; Mode = 2'b11; D4 = 4'h6;
      tick();
      Mode = 2'b01;
      tick();
      En = 0;
      repeat (2) begin
         tick();
         checks++;
         if (qa !== 4'h7 || wra !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold: q=%h wrap=%b, want q=7 wrap=0", qa, wra);
         end
      end
      En = 1; Reset = 1;
      tick();
      Reset = 0;
      checks++;
      if (qa !== 4'hA || tca !== 1'b0 || wra !== 1'b0 || observed() !== expected()) begin
         errors++;
         $display("FAIL mid_reset: q=%h tc=%b wrap=%b, want q=a tc=0 wrap=0", qa, tca, wra);
      end
   endtask

   task automatic test_width16();
      En = 1; Mode = 2'b11; D16 = 16'hFFFE;
      tick();
      Mode = 2'b01;
      tick();
      checks++;
      if (qw !== 16'hFFFF || tcw !== 1'b1 || wrw !== 1'b0) begin
         errors++;
         $display("FAIL width16_ffff: q=%h tc=%b wrap=%b, want ffff 1 0", qw, tcw, wrw);
      end
      tick();
      checks++;
      if (qw !== 16'h0000 || tcw !== 1'b0 || wrw !== 1'b1 || qbw !== 16'hFFFF) begin
         errors++;
         $display("FAIL width16_wrap: q=%h qbar=%h tc=%b wrap=%b, want 0000 ffff 0 1", qw, qbw, tcw, wrw);
      end
   endtask

   task automatic test_back_to_back();
      En = 1; Mode = 2'b11; D4 = 4'hF;
      tick();
      for (int i = 0; i < 4; i++) begin
         Mode = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         checks++;
         if (wra !== 1'b1 || qa !== ((i % 2 == 0) ? 4'h0 : 4'hF)) begin
            errors++;
            $display("FAIL back_to_back step %0d: q=%h wrap=%b, want wrap=1", i, qa, wra);
         end
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL back_to_back_model step %0d: got %h want %h", i, observed(), expected());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         Reset = ($urandom_range(31) == 0);
         En    = ($urandom_range(3) != 0);
         Mode  = 2'($urandom_range(3));
         J4  = 4'($urandom);  K4  = 4'($urandom);  D4  = 4'($urandom);
         J16 = 16'($urandom); K16 = 16'($urandom);
         D16 = ($urandom_range(3) == 0) ? 16'hFFFF - 16'($urandom_range(2)) : 16'($urandom);
         tick();
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL random step %0d: got %h want %h", i, observed(), expected());
         end
      end
      Reset = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      Reset = 1; En = 0; Mode = 2'b00;
      J4 = '0; K4 = '0; D4 = '0; J16 = '0; K16 = '0; D16 = '0;
      ma_q = '0; ms_q = '0; mw_q = '0;
      test_reset();
      test_jk();
      test_count_up();
      test_count_down();
      test_mid_control();
      test_width16();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_register_counter.md
Name: jk_register_counter

Overview:
- Parametrised WIDTH-bit register built from JK cells, with a bitwise JK mode, up/down counter modes and a parallel-load mode.
- Adds clock enable, registered terminal-count and wrap flags, and optional saturation.
- Next-generation replacement for the single-bit JK flip-flop in the flip-flop library.
- Used as a general state/counter element in lab datapaths.

Parameters:
- WIDTH, 8: register width in bits; 2 or greater.
- RESET_VALUE, 0: value loaded into Q on Reset; WIDTH bits.
- SATURATE, 0: 0 = counter wraps around; 1 = counter holds at its limit.

Ports:
- Clk  input  1: clock; all state updates on the falling edge.
- Reset  input  1: synchronous, active-high reset.
- En  input  1: clock enable; 0 = hold all state.
- Mode  input  2: 00 JK bitwise, 01 count up, 10 count down, 11 parallel load.
- J  input  WIDTH: per-bit J in JK mode; ignored otherwise.
- K  input  WIDTH: per-bit K in JK mode; ignored otherwise.
- D  input  WIDTH: parallel load data for Mode 11.
- Q  output  WIDTH: register state.
- Q_bar  output  WIDTH: bitwise complement of Q, valid in the same cycle as Q (combinational from Q, never one edge late).
- TC  output  1: registered terminal count.
- Wrap  output  1: registered one-cycle pulse on counter roll-over.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high. All registers update only on the falling edge of Clk.
- Priority on each falling edge: Reset, then En=0, then Mode.
- Reset=1:
  - Q <= RESET_VALUE; TC <= 0; Wrap <= 0.
  - Q_bar follows as ~RESET_VALUE.
  - Reset asserted mid-count aborts the count on that edge; no flag pulses.
- En=0: Q and TC hold; Wrap <= 0.
- Mode 00, JK bitwise, per bit i:
  - J=0, K=0: hold.
  - J=1, K=0: set to 1.
  - J=0, K=1: clear to 0.
  - J=1, K=1: toggle.
  - TC <= 0; Wrap <= 0.
- Mode 01, count up:
  - Each bit i is a JK cell with J=K=T(i). T(0)=1; T(i)=AND of Q[i-1:0].
  - Gives Q+1 modulo 2^WIDTH.
  - At Q = all-ones with SATURATE=0: Q <= 0 and Wrap <= 1.
  - At Q = all-ones with SATURATE=1: Q holds and Wrap <= 0.
  - TC <= (next Q == all-ones).
- Mode 10, count down:
  - T(0)=1; T(i)=AND of ~Q[i-1:0].
  - At Q = 0 with SATURATE=0: Q <= all-ones and Wrap <= 1.
  - At Q = 0 with SATURATE=1: Q holds at 0 and Wrap <= 0.
  - TC <= (next Q == 0).
- Mode 11, load: Q <= D; TC <= 0; Wrap <= 0.
- Wrap is high for exactly one cycle per roll-over. Consecutive roll-overs (WIDTH small, continuous counting) give separate pulses.
- TC and Wrap reflect the edge that produced the current Q, with zero latency relative to Q.
- Mode changes take effect on the next falling edge. No state is carried between modes except Q.
- Arithmetic is unsigned, WIDTH bits, with no carry-out other than Wrap.
- No X propagation: every output has a defined value from the first Reset edge onward.

Decomposition:
- Package jk_pkg:
  - MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
  - Typedef jk_mode_t for Mode.
- Sub-module jk_cell:
  - One bit, falling-edge, synchronous Reset with a reset-value input.
  - Inputs: En, J, K, Load, D.
  - Output: Q.
  - Instantiated WIDTH times by a generate loop.
- Top level computes the per-bit J/K/Load from Mode, the toggle chain and saturation, then registers TC and Wrap.

Test Plan:
- Reset sequence, WIDTH=4, RESET_VALUE=4'hA: Reset=1 for 2 edges -> Q=4'hA, Q_bar=4'h5, TC=0, Wrap=0. Then Reset=0 with En=0 for 3 edges -> Q stays 4'hA.
- JK mode, WIDTH=4, Q=4'b0101, J=4'b1100, K=4'b1010, one edge -> bit3 toggles to 1, bit2 set stays 1, bit1 clears to 0, bit0 holds 1 -> Q=4'b1101.
- Count up, WIDTH=4, SATURATE=0, load D=4'hD, then 3 up edges:
  - Q goes 4'hE, 4'hF, 4'h0.
  - TC=1 only after 4'hF.
  - Wrap=1 only on the edge that produces 4'h0.
- Count down, WIDTH=4, SATURATE=1, load D=4'h1, then 3 down edges -> Q goes 4'h0, 4'h0, 4'h0; TC=1 throughout; Wrap never asserts.
- Mid-operation control: counting up at Q=4'h7, assert En=0 for 2 edges then Reset=1 for 1 edge:
  - Q holds 4'h7, then becomes RESET_VALUE.
  - TC=0 and Wrap=0 after the Reset edge.
- Width generality: WIDTH=16, load 16'hFFFE, 2 up edges with SATURATE=0 -> Q=16'hFFFF (TC=1), then 16'h0000 (Wrap=1, TC=0).
